hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage CPU (F/D/E/M/W).
- Produces the 2-bit select for the two execute-stage operand forwarding muxes (3:1).
- Generates stall and flush controls for load-use hazards, taken branches/jumps, and multi-cycle execute ops.
- Sits beside the datapath: reads register indices and control bits from the D/E/M/W pipeline registers and drives pipeline-register enables/clears plus forwarding selects.

---
 rtl/hazard_unit.sv | 137 +++++++++++++
 tb/tb_hazard_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: E-stage forwarding selects, load-use stall, branch flush, multi-cycle E hold.
// Forwarding, stalls and flushes are combinational from the current pipeline registers; only the multi-cycle counter is registered.
module hazard_unit #(
    parameter int REG_W    = 4,
    parameter int MC_LAT   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             mc_start_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mc_busy
);

    if (MC_LAT < 2 || MC_LAT > 16) begin : g_bad_mc_lat
        $error("hazard_unit: MC_LAT must lie in 2..16");
    end

    // The op spends one cycle in IDLE (the start cycle) before BUSY counts down to zero.
    localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mc_stall;
    logic       mc_busy_raw;
    logic       lw_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             wr_m,
        input logic [REG_W-1:0] dst_m,
        input logic             wr_w,
        input logic [REG_W-1:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!(ZERO_REG && rs == '0)) begin
            if (wr_m && dst_m == rs) begin
                sel = 2'b10;
            end else if (wr_w && dst_w == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign lw_stall = load_e && (rs1_d == rd_e || rs2_d == rd_e)
                      && !(ZERO_REG && rd_e == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_stall    = 1'b0;
        mc_busy_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start_e) begin
                    mc_stall    = 1'b1;
                    mc_busy_raw = 1'b1;
                    state_d     = BUSY;
                    cnt_d       = CNT_INIT;
                end
            end
            BUSY: begin
                mc_busy_raw = 1'b1;
                // Last occupied cycle: release the pipe; mc_start_e still belongs to this op.
                if (cnt_q != 4'd0) begin
                    mc_stall = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        mc_busy     = 1'b0;
        if (!reset) begin
            forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
            forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
            stall_f     = lw_stall || mc_stall;
            stall_d     = lw_stall || mc_stall;
            stall_e     = mc_stall;
            flush_m     = mc_stall;
            flush_e     = (lw_stall || pc_src_e) && !mc_stall;
            flush_d     = pc_src_e && !mc_stall;
            mc_busy     = mc_busy_raw;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against an age-based reference model.
module tb_hazard_unit;

    localparam int REG_W    = 4;
    localparam int MC_LAT   = 4;
    localparam bit ZERO_REG = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [REG_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             reg_write_m, reg_write_w, load_e, pc_src_e, mc_start_e;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;

    hazard_unit #(.REG_W(REG_W), .MC_LAT(MC_LAT), .ZERO_REG(ZERO_REG)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .mc_busy(mc_busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [10:0] dut_v;
    assign dut_v = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
                    flush_d, flush_e, flush_m, mc_busy};

    // Reference: age of the op currently in E (-1 = no multi-cycle op).
    int m_age = -1;
    always @(posedge clk) begin
        if (reset)               m_age <= -1;
        else if (m_age >= 0)     m_age <= (m_age + 1 == MC_LAT) ? -1 : m_age + 1;
        else if (mc_start_e)     m_age <= 1;
    end

    function automatic logic [1:0] m_fwd(input logic [REG_W-1:0] rs);
        if (ZERO_REG && rs == 0)           return 2'd0;
        if (reg_write_m && rd_m == rs)     return 2'd2;
        if (reg_write_w && rd_w == rs)     return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [10:0] model_v();
        logic lw, mst, busy;
        if (reset) return 11'd0;
        lw   = load_e && (rs1_d == rd_e || rs2_d == rd_e) && !(ZERO_REG && rd_e == 0);
        busy = (m_age >= 0) || mc_start_e;
        mst  = (m_age >= 0) ? (m_age < MC_LAT - 1) : mc_start_e;
        return {m_fwd(rs1_e), m_fwd(rs2_e), lw || mst, lw || mst, mst,
                pc_src_e && !mst, (lw || pc_src_e) && !mst, mst, busy};
    endfunction

    task clear_inputs();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {reg_write_m, reg_write_w, load_e, pc_src_e, mc_start_e} = '0;
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task randomize_inputs();
        rs1_d = 4'($urandom_range(0, 3));
        rs2_d = 4'($urandom_range(0, 3));
        rs1_e = 4'($urandom_range(0, 3));
        rs2_e = 4'($urandom_range(0, 3));
        rd_e  = 4'($urandom_range(0, 3));
        rd_m  = 4'($urandom_range(0, 3));
        rd_w  = 4'($urandom_range(0, 3));
        reg_write_m = 1'($urandom_range(0, 1));
        reg_write_w = 1'($urandom_range(0, 1));
        load_e      = 1'($urandom_range(0, 1));
        pc_src_e    = 1'($urandom_range(0, 1));
    endtask

    task test_reset();
        for (int c = 0; c < 4; c++) begin
            step();
            reset = 1'b1;
            randomize_inputs();
            mc_start_e = 1'($urandom_range(0, 1));
            #3;
            checks++;
            if (dut_v !== 11'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", c, dut_v, 11'd0);
            end
        end
        step();
        reset = 1'b0;
        clear_inputs();
        #3;
        checks++;
        if (dut_v !== model_v() || mc_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", dut_v, model_v());
        end
    endtask

    task test_forwarding();
        step();
        clear_inputs();
        reg_write_m = 1; rd_m = 5; rs1_e = 5; reg_write_w = 1; rd_w = 5; rs2_e = 5;
        #3;
        checks++;
        if (forward_a_e !== 2'b10 || forward_b_e !== 2'b10) begin
            failures++;
            $display("FAIL fwd_m_priority got=%b/%b exp=10/10", forward_a_e, forward_b_e);
        end
        reg_write_m = 0;
        #1;
        checks++;
        if (forward_a_e !== 2'b01 || forward_b_e !== 2'b01) begin
            failures++;
            $display("FAIL fwd_w got=%b/%b exp=01/01", forward_a_e, forward_b_e);
        end
        reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0;
        #1;
        checks++;
        if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
            failures++;
            $display("FAIL fwd_zero_reg got=%b/%b exp=00/00", forward_a_e, forward_b_e);
        end
        for (int i = 0; i < 60; i++) begin
            step();
            randomize_inputs();
            load_e = 0; pc_src_e = 0;
            #3;
            checks++;
            if (dut_v !== model_v()) begin
                failures++;
                $display("FAIL fwd_random i=%0d got=%b exp=%b", i, dut_v, model_v());
            end
        end
    endtask

    task test_load_use();
        step();
        clear_inputs();
        load_e = 1; rd_e = 3; rs2_d = 3;
        #3;
        checks++;
        if ({stall_f, stall_d, flush_e, stall_e} !== 4'b1110) begin
            failures++;
            $display("FAIL load_use got=%b exp=1110", {stall_f, stall_d, flush_e, stall_e});
        end
        rd_e = 0;
        #1;
        checks++;
        if ({stall_f, stall_d, flush_e, stall_e} !== 4'b0000) begin
            failures++;
            $display("FAIL load_use_r0 got=%b exp=0000", {stall_f, stall_d, flush_e, stall_e});
        end
    endtask

    task test_branch();
        for (int c = 0; c < 3; c++) begin
            step();
            clear_inputs();
            pc_src_e = (c == 1);
            #3;
            checks++;
            if ({flush_d, flush_e, stall_f, stall_d, stall_e} !== {(c == 1), (c == 1), 3'b000}) begin
                failures++;
                $display("FAIL branch cyc=%0d got=%b exp=%b", c,
                         {flush_d, flush_e, stall_f, stall_d, stall_e}, {(c == 1), (c == 1), 3'b000});
            end
        end
    endtask

    task test_multicycle();
        for (int c = 0; c < 5; c++) begin
            step();
            clear_inputs();
            mc_start_e = (c <= 3);
            #3;
            checks++;
            if (dut_v !== model_v() || stall_e !== (c < 3) || flush_m !== (c < 3)
                || mc_busy !== (c < 4)) begin
                failures++;
                $display("FAIL multicycle cyc=%0d got=%b exp=%b", c, dut_v, model_v());
            end
        end
    endtask

    task test_mc_load_use();
        for (int c = 0; c < 4; c++) begin
            step();
            clear_inputs();
            mc_start_e = (c == 0);
            load_e = 1; rd_e = 6; rs1_d = 6;
            #3;
            checks++;
            if (flush_e !== (c == 3) || stall_d !== 1'b1 || dut_v !== model_v()) begin
                failures++;
                $display("FAIL mc_load_use cyc=%0d got=%b exp=%b", c, dut_v, model_v());
            end
        end
        step();
        clear_inputs();
    endtask

    task test_reset_mid_op();
        step();
        clear_inputs();
        mc_start_e = 1;
        step();
        reset = 1;
        randomize_inputs();
        #3;
        checks++;
        if (dut_v !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_op got=%b exp=%b", dut_v, 11'd0);
        end
        step();
        reset = 0;
        clear_inputs();
        #3;
        checks++;
        if (mc_busy !== 1'b0 || stall_e !== 1'b0 || dut_v !== model_v()) begin
            failures++;
            $display("FAIL reset_mid_op_release got=%b exp=%b", dut_v, model_v());
        end
    endtask

    task test_random();
        for (int i = 0; i < 400; i++) begin
            step();
            randomize_inputs();
            reset      = ($urandom_range(0, 39) == 0);
            mc_start_e = ($urandom_range(0, 5) == 0);
            pc_src_e   = ($urandom_range(0, 5) == 0);
            #3;
            checks++;
            if (dut_v !== model_v()) begin
                failures++;
                $display("FAIL random i=%0d age=%0d got=%b exp=%b", i, m_age, dut_v, model_v());
            end
        end
        step();
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multicycle();
        test_mc_load_use();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
